// File: rtl/pll_sched_pkg.sv
// ----------------------------------------------------------------------------
// pll_sched_pkg
// Shared constants, types and helpers for the PLL load scheduler.
//   NUM_PLL        default number of adf4159 driver channels
//   INT_W / FRAC_W widths of the INT and FRAC frequency words
//   CHAN_W         width of the 1-based channel ID on the config bus
//   sched_state_e  scheduler FSM encoding
//   freq_word_t    one INT/FRAC pair as held in a shadow slot
//   chan_to_pair   maps a 0-based channel index to its trigger pair
// ----------------------------------------------------------------------------
package pll_sched_pkg;

    localparam int NUM_PLL = 6;
    localparam int INT_W   = 12;
    localparam int FRAC_W  = 25;
    localparam int CHAN_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_HI,
        WAIT_LO,
        LOCK_WAIT,
        FAIL
    } sched_state_e;

    typedef struct packed {
        logic [INT_W-1:0]  int_w;
        logic [FRAC_W-1:0] frac_w;
    } freq_word_t;

    // Channels {2k, 2k+1} (0-based) share trigger bit k.
    function automatic int chan_to_pair(input int idx);
        return idx / 2;
    endfunction

endpackage

// File: rtl/pll_rr_arbiter.sv
// ----------------------------------------------------------------------------
// pll_rr_arbiter
// Combinational round-robin pick: grants the first requester strictly after
// the last-served index, wrapping around to index 0.
//   req    request vector, one bit per channel
//   ptr    index of the channel served last
//   gnt    one-hot grant (all zero when nothing is requested)
//   valid  a grant is present
// ----------------------------------------------------------------------------
module pll_rr_arbiter #(
    parameter int N     = 6,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic             valid
);

    logic found;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        // First pass: requesters above the pointer, lowest index first.
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (PTR_W'(i) > ptr)) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
        // Wrap-around pass: lowest requester overall.
        for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    assign valid = found;

endmodule

// File: rtl/pll_load_scheduler.sv
// ----------------------------------------------------------------------------
// pll_load_scheduler
// Holds per-PLL shadow INT/FRAC words from the command decoder, arms them
// immediately or on a frequency trigger, and hands them one at a time
// (round-robin) to the adf4159 drivers with a load/busy handshake under
// timeout supervision.
//
// Build option: define PLL_LOCK_CHECK_EN to wait for lock[ch] after busy falls
// (bounded by LOCK_TIMEOUT) before reporting done. Without it, lock is unused.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   cfg_*           config write: channel (1..NUM_PLL), INT, FRAC, immediate
//   cfg_ready       1 whenever not in reset
//   cfg_err         one-cycle pulse after a write to an invalid channel
//   trig[2:0]       async triggers, bit k arms pending channels of pair k
//   load / busy     per-driver handshake (at most one load bit high)
//   ints / fracs    active words, channel i at [INT_W*i +: INT_W] etc.
//   pend            written but not yet issued
//   done/done_chan  completion pulse and ID of the last completed channel
//   err / err_clr   sticky per-channel timeout flags and their clear
//   lock            PLL lock indications (lock-check build only)
// ----------------------------------------------------------------------------
module pll_load_scheduler
    import pll_sched_pkg::*;
#(
    parameter int                NUM_PLL      = pll_sched_pkg::NUM_PLL,
    parameter int                BUSY_TIMEOUT = 4096,
    parameter int                LOCK_TIMEOUT = 65536,
    parameter logic [INT_W-1:0]  RST_INT      = '0,
    parameter logic [FRAC_W-1:0] RST_FRAC     = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [CHAN_W-1:0]         cfg_chan,
    input  logic [INT_W-1:0]          cfg_int,
    input  logic [FRAC_W-1:0]         cfg_frac,
    input  logic                      cfg_immediate,
    output logic                      cfg_err,
    input  logic [2:0]                trig,
    output logic [NUM_PLL-1:0]        load,
    input  logic [NUM_PLL-1:0]        busy,
    output logic [INT_W*NUM_PLL-1:0]  ints,
    output logic [FRAC_W*NUM_PLL-1:0] fracs,
    output logic [NUM_PLL-1:0]        pend,
    output logic                      done,
    output logic [CHAN_W-1:0]         done_chan,
    output logic [NUM_PLL-1:0]        err,
    input  logic                      err_clr,
    input  logic [NUM_PLL-1:0]        lock
);

    localparam int PTR_W   = (NUM_PLL > 1) ? $clog2(NUM_PLL) : 1;
    localparam int TMO_MAX = (BUSY_TIMEOUT > LOCK_TIMEOUT) ? BUSY_TIMEOUT : LOCK_TIMEOUT;
    localparam int CNT_W   = $clog2(TMO_MAX + 1);

    sched_state_e        state, state_next;
    freq_word_t          shadow [NUM_PLL];
    logic [NUM_PLL-1:0]  armed;
    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    cur_ch;
    logic [PTR_W-1:0]    gnt_idx;
    logic [NUM_PLL-1:0]  eligible;
    logic [NUM_PLL-1:0]  gnt;
    logic                gnt_valid;
    logic [CNT_W-1:0]    tmo_cnt;
    logic                busy_tmo;
    logic [2:0]          trig_s1, trig_s2, trig_d;
    logic [2:0]          trig_edge;
    logic [NUM_PLL-1:0]  pair_edge;
    logic [NUM_PLL-1:0]  wr_hit;
    logic                chan_ok;
    logic                done_set;
    logic                fail_set;

    assign cfg_ready = ~rst;

    // ------------------------------------------------------------------
    // Config decode and trigger edges
    // ------------------------------------------------------------------
    assign chan_ok   = (cfg_chan != '0) && (cfg_chan <= CHAN_W'(NUM_PLL));
    assign trig_edge = trig_s2 & ~trig_d;

    for (genvar g = 0; g < NUM_PLL; g++) begin : g_chan
        assign wr_hit[g]    = cfg_valid && chan_ok && (cfg_chan == CHAN_W'(g + 1));
        assign pair_edge[g] = trig_edge[chan_to_pair(g)];
    end

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign eligible = pend & armed;

    pll_rr_arbiter #(
        .N     (NUM_PLL),
        .PTR_W (PTR_W)
    ) u_arb (
        .req   (eligible),
        .ptr   (ptr),
        .gnt   (gnt),
        .valid (gnt_valid)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_PLL; i++) begin
            if (gnt[i]) gnt_idx = PTR_W'(i);
        end
    end

    // Count reaches the limit at the end of this cycle.
    assign busy_tmo = (tmo_cnt == CNT_W'(BUSY_TIMEOUT - 1));

`ifdef PLL_LOCK_CHECK_EN
    logic lock_tmo;
    assign lock_tmo = (tmo_cnt == CNT_W'(LOCK_TIMEOUT - 1));
`else
    logic unused_lock;
    assign unused_lock = ^lock;
`endif

    // ------------------------------------------------------------------
    // Scheduler FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state is assigned with non-blocking (<=) so every
    // flop samples values from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tmo_cnt <= '0;
        end else begin
            state   <= state_next;
            tmo_cnt <= (state_next != state) ? '0 : tmo_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Scheduler FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        load       = '0;
        done_set   = 1'b0;
        fail_set   = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_valid) state_next = ISSUE;
            end
            ISSUE: begin
                load[cur_ch] = 1'b1;
                state_next   = WAIT_HI;
            end
            WAIT_HI: begin
                load[cur_ch] = 1'b1;
                if (busy[cur_ch])  state_next = WAIT_LO;
                else if (busy_tmo) state_next = FAIL;
            end
            WAIT_LO: begin
                if (!busy[cur_ch]) begin
`ifdef PLL_LOCK_CHECK_EN
                    state_next = LOCK_WAIT;
`else
                    state_next = IDLE;
                    done_set   = 1'b1;
`endif
                end else if (busy_tmo) begin
                    state_next = FAIL;
                end
            end
`ifdef PLL_LOCK_CHECK_EN
            LOCK_WAIT: begin
                if (lock[cur_ch]) begin
                    state_next = IDLE;
                    done_set   = 1'b1;
                end else if (lock_tmo) begin
                    state_next = FAIL;
                end
            end
`endif
            FAIL: begin
                fail_set   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: shadows, pend/armed, active words, status
    // ------------------------------------------------------------------
    // NOTE: the shadow array is reset along with everything else so a word
    // written before a reset can never be issued after it; it is only a few
    // flops per channel, not a RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_s1   <= '0;
            trig_s2   <= '0;
            trig_d    <= '0;
            cfg_err   <= 1'b0;
            done      <= 1'b0;
            done_chan <= '0;
            ptr       <= PTR_W'(NUM_PLL - 1);
            cur_ch    <= '0;
            pend      <= '0;
            armed     <= '0;
            err       <= '0;
            for (int i = 0; i < NUM_PLL; i++) begin
                shadow[i]                   <= '0;
                ints[i*INT_W +: INT_W]      <= RST_INT;
                fracs[i*FRAC_W +: FRAC_W]   <= RST_FRAC;
            end
        end else begin
            trig_s1 <= trig;
            trig_s2 <= trig_s1;
            trig_d  <= trig_s2;
            cfg_err <= cfg_valid & ~chan_ok;
            done    <= done_set;
            if (done_set) done_chan <= CHAN_W'(cur_ch) + CHAN_W'(1);
            if (state == IDLE && gnt_valid) cur_ch <= gnt_idx;
            if (state == ISSUE) ptr <= cur_ch;

            for (int i = 0; i < NUM_PLL; i++) begin
                if (state == ISSUE && cur_ch == PTR_W'(i)) begin
                    ints[i*INT_W +: INT_W]    <= shadow[i].int_w;
                    fracs[i*FRAC_W +: FRAC_W] <= shadow[i].frac_w;
                    pend[i]                   <= 1'b0;
                    armed[i]                  <= 1'b0;
                end else if (pair_edge[i] && pend[i]) begin
                    armed[i] <= 1'b1;
                end
                // A write wins over the issue clear: the channel is re-pended
                // with the new word for a later load.
                if (wr_hit[i]) begin
                    shadow[i] <= '{int_w: cfg_int, frac_w: cfg_frac};
                    pend[i]   <= 1'b1;
                    armed[i]  <= cfg_immediate | pair_edge[i];
                end
                if (err_clr) begin
                    err[i] <= 1'b0;
                end else if (fail_set && cur_ch == PTR_W'(i)) begin
                    err[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/pll_load_scheduler.md
Name: pll_load_scheduler

Overview:
- Sequences frequency-word loads into the six adf4159 serial drivers. Holds per-PLL shadow INT/FRAC words written by the command decoder, arms them immediately or on a frequency trigger, and grants one driver at a time round-robin.
- Performs the load/busy handshake with each driver, with timeout supervision.
- Sits between the master SPI command decoder and the adf4159 driver array, replacing ad-hoc per-pair load FSMs.

Parameters:
- NUM_PLL, 6, number of driver channels (channel IDs 1..NUM_PLL on cfg bus)
- BUSY_TIMEOUT, 4096, max cycles waiting for each busy edge
- LOCK_TIMEOUT, 65536, max cycles waiting for lock after load (optional feature only)
- RST_INT, 0, reset value of active INT outputs
- RST_FRAC, 0, reset value of active FRAC outputs

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cfg_valid  in  1  config write strobe
- cfg_ready  out  1  always 1 out of reset; 0 during reset
- cfg_chan  in  4  target channel, 1..NUM_PLL
- cfg_int  in  12  INT word
- cfg_frac  in  25  FRAC word
- cfg_immediate  in  1  arm without trigger
- cfg_err  out  1  one-cycle pulse on invalid cfg_chan
- trig  in  3  async triggers; bit k arms PLL pair {2k,2k+1}
- load  out  NUM_PLL  per-driver load request
- busy  in  NUM_PLL  per-driver busy
- ints  out  12*NUM_PLL  active INT words, channel i at [12i+:12]
- fracs  out  25*NUM_PLL  active FRAC words, channel i at [25i+:25]
- pend  out  NUM_PLL  pending (written, not yet issued)
- done  out  1  one-cycle pulse on successful load completion
- done_chan  out  4  channel ID of last done, held until the next done
- err  out  NUM_PLL  sticky timeout error per channel
- err_clr  in  1  clears all err bits
- lock  in  NUM_PLL  PLL lock indications (used only with the optional feature)

Behaviour:
- Reset values: all outputs 0; ints = RST_INT; fracs = RST_FRAC; last-served pointer = NUM_PLL-1. Reset mid-operation aborts immediately: load drops the cycle after rst, and shadow, pending and armed state are cleared.
- Config write:
  - A cfg_valid with a valid channel writes shadow[ch-1], sets pend and sets armed = cfg_immediate.
  - A rewrite before issue overwrites the shadow (last write wins); the armed value is taken from the new write, ORed with any trigger edge in the same cycle.
  - A write to the channel currently being loaded updates the shadow and re-pends it for a later load.
  - cfg_chan of 0 or greater than NUM_PLL: write dropped, cfg_err pulses the next cycle.
- Triggers: 2-flop synchronizer, then rising-edge detect. An edge on bit k arms every pending channel in pair k. An edge with no pending channel is discarded, not remembered.
- Scheduler FSM:
  - IDLE: eligible = pend & armed. If nonzero, grant the first eligible channel after the last-served pointer (wrap-around) and go to ISSUE.
  - ISSUE (1 cycle): copy shadow into active ints/fracs slice, clear pend/armed for that channel, assert load[ch], update pointer, go to WAIT_HI.
  - WAIT_HI: hold load until busy[ch]=1, then drop load and go to WAIT_LO. On timeout, go to FAIL.
  - WAIT_LO: wait for busy[ch]=0, then pulse done, set done_chan, go to IDLE. On timeout, go to FAIL.
  - FAIL (1 cycle): load=0, set err[ch], no done, go to IDLE.
- Latency: an immediate write accepted at cycle 0 on an idle scheduler gives load=1 at cycle 2 (pend visible at cycle 1, ISSUE at cycle 2).
- Timeout counter: resets on every state entry; fails when the count reaches BUSY_TIMEOUT.
- Error clear: err_clr has priority over a simultaneous err set. An err bit does not block future loads.
- Only one load bit is ever high.

Optional Feature:
- Macro: PLL_LOCK_CHECK_EN.
- With the macro: after busy falls in WAIT_LO, enter LOCK_WAIT and wait for lock[ch]=1.
  - Lock seen: pulse done.
  - LOCK_TIMEOUT expires: go to FAIL and set err[ch].
- Without the macro: no LOCK_WAIT state; the lock input is unused; done follows busy falling.

Decomposition:
- Package pll_sched_pkg holds:
  - NUM_PLL, INT_W=12, FRAC_W=25, CHAN_W=4
  - state encoding {IDLE, ISSUE, WAIT_HI, WAIT_LO, LOCK_WAIT, FAIL}
  - chan_to_pair function
- One sub-module, pll_rr_arbiter: combinational round-robin pick from request vector and pointer, returning one-hot grant and a valid flag.

Test Plan:
- Immediate write chan 3, int=188, frac=3519526; busy model rises after 3 cycles and falls after 40 cycles -> load[2]=1 at cycle 2; ints[24+:12]=188; done pulses once with done_chan=3; pend=0.
- Non-immediate writes to chan 1 and chan 2 -> no load for 100 cycles. Then trig[0] rising edge -> chan 1 loaded, then chan 2; never overlapping; two done pulses.
- Chans 1, 5 and 6 pending and armed, pointer at chan 5 -> grant order 6, 1, 5.
- BUSY_TIMEOUT=16, busy stuck 0 on chan 4 -> load drops after 16 WAIT_HI cycles, err[3]=1, no done. err_clr -> err=0. Next load on chan 4 proceeds normally.
- rst asserted during WAIT_LO -> next cycle load=0, pend=0, err=0, ints/fracs=reset values.
- cfg_chan=0, then cfg_chan=7 -> two cfg_err pulses; pend, shadows and load unchanged.
